// File: rtl/aes192_io_pkg.sv
// Shared types and constants for the AES-192 word-serial front end.
package aes192_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    WAIT,
    DRAIN
  } state_t;

  localparam int unsigned KEY_WORDS    = 6;
  localparam int unsigned BLK_WORDS    = 4;
  localparam int unsigned FULL_WORDS   = 10;
  localparam int unsigned CORE_LATENCY = 26;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned KEY_W   = KEY_WORDS * WORD_W;
  localparam int unsigned BLK_W   = BLK_WORDS * WORD_W;
  localparam int unsigned CHAIN_W = KEY_W + BLK_W;

endpackage

// File: rtl/aes_192_word_io.sv
// Word-serial load/drain wrapper around the unrolled AES-192 encryption core.
module aes_192_word_io
  import aes192_io_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         aes_start,
  output logic [127:0] aes_state,
  output logic [191:0] aes_key,
  input  logic [127:0] aes_out,
  input  logic         aes_out_valid,
  output logic         busy,
  output logic         err_len,
  output logic         err_timeout
);

  state_t               state_q, state_d;
  logic [CHAIN_W-1:0]   chain_q, chain_d;
  logic [KEY_W-1:0]     key_q;
  logic [BLK_W-1:0]     pt_q;
  logic [BLK_W-1:0]     res_q;
  logic                 key_loaded_q;
  logic [3:0]           cnt_q, cnt_d;
  logic [15:0]          tcnt_q;
  logic [1:0]           idx_q;
  logic                 err_len_q, err_to_q;
  logic                 s_acc, last_acc, full_ok, blk_ok, to_hit, m_hs;

  assign s_acc    = s_valid & s_ready;
  assign last_acc = s_acc & s_last;
  assign chain_d  = {chain_q[CHAIN_W-WORD_W-1:0], s_data};
  // Count including the word being accepted, saturating one past a full block.
  assign cnt_d    = (cnt_q == 4'(FULL_WORDS + 1)) ? cnt_q : cnt_q + 4'd1;
  assign full_ok  = (cnt_d == 4'(FULL_WORDS));
  assign blk_ok   = (cnt_d == 4'(BLK_WORDS)) & key_loaded_q;
  assign to_hit   = (tcnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign m_hs     = m_valid & m_ready;

  assign aes_state   = pt_q;
  assign aes_key     = key_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (last_acc && (full_ok || blk_ok)) state_d = START;
      START:   state_d = GAP;
      GAP:     state_d = WAIT;
      WAIT:    if (aes_out_valid) state_d = DRAIN;
               else if (to_hit)   state_d = IDLE;
      DRAIN:   if (m_hs && idx_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stream handshakes, core start strobe and ciphertext word select.
  always_comb begin
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    aes_start = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
      end
      START: aes_start = 1'b1;
      DRAIN: begin
        m_valid = 1'b1;
        m_last  = (idx_q == 2'd3);
        case (idx_q)
          2'd0:    m_data = res_q[127:96];
          2'd1:    m_data = res_q[95:64];
          2'd2:    m_data = res_q[63:32];
          default: m_data = res_q[31:0];
        endcase
      end
      default: ;
    endcase
  end

  // Load chain, key/plaintext/result registers, counters and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q      <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      res_q        <= '0;
      key_loaded_q <= 1'b0;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      idx_q        <= '0;
      err_len_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_acc) begin
            chain_q <= chain_d;
            if (s_last) begin
              cnt_q <= '0;
              if (full_ok) begin
                key_q        <= chain_d[CHAIN_W-1:BLK_W];
                pt_q         <= chain_d[BLK_W-1:0];
                key_loaded_q <= 1'b1;
              end else if (blk_ok) begin
                pt_q <= chain_d[BLK_W-1:0];
              end else begin
                err_len_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        GAP: begin
          tcnt_q <= '0;
          idx_q  <= '0;
        end
        WAIT: begin
          if (aes_out_valid) res_q    <= aes_out;
          else if (to_hit)   err_to_q <= 1'b1;
          else               tcnt_q   <= tcnt_q + 16'd1;
        end
        DRAIN: if (m_hs) idx_q <= idx_q + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_192_word_io.sv
// Directed bench for aes_192_word_io with a behavioural AES-192 core stub.
module tb_aes_192_word_io;
  import aes192_io_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [31:0]  m_data;
  logic         m_last;
  logic         aes_start;
  logic [127:0] aes_state;
  logic [191:0] aes_key;
  logic [127:0] aes_out = '0;
  logic         aes_out_valid = 1'b0;
  logic         busy;
  logic         err_len;
  logic         err_timeout;

  aes_192_word_io #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .aes_start(aes_start), .aes_state(aes_state), .aes_key(aes_key),
    .aes_out(aes_out), .aes_out_valid(aes_out_valid),
    .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  int unsigned t_acc = 0;
  logic [31:0] wq[$];

  localparam logic [191:0] K  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;

  // Stub: only the FIPS-197 C.2 pair maps to its ciphertext; anything else is a simple mix.
  function automatic logic [127:0] core_fn(input logic [191:0] k, input logic [127:0] s);
    if (k == K && s == P) return C;
    return s ^ k[191:64];
  endfunction

  logic         core_dead = 1'b0;
  logic         start_prev = 1'b0;
  int           ccnt = 0;
  logic [191:0] lk = '0;
  logic [127:0] ls = '0;

  // Core model: out_valid rises 26 cycles after the start cycle, drops on the next start edge.
  always @(posedge clk) begin
    start_prev <= aes_start;
    if (aes_start && !start_prev) begin
      aes_out_valid <= 1'b0;
      ccnt          <= int'(CORE_LATENCY) - 1;
      lk            <= aes_key;
      ls            <= aes_state;
    end else if (ccnt > 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1 && !core_dead) begin
        aes_out_valid <= 1'b1;
        aes_out       <= core_fn(lk, ls);
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_q();
    for (int i = 0; i < wq.size(); i++) begin
      s_valid = 1'b1;
      s_data  = wq[i];
      s_last  = (i == wq.size() - 1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    t_acc   = cyc;
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | m_valid | aes_start;
    end
    chk(tag, seen, 0);
  endtask

  task automatic illegal(input string tag);
    send_q();
    chk({tag, "_err_len"}, err_len, 1);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    tick();
    chk({tag, "_err_len_pulse"}, err_len, 0);
    quiet({tag, "_no_output"}, 40);
  endtask

  task automatic wait_mv(input string tag);
    int unsigned n;
    n = 0;
    while (!m_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, cyc - t_acc + 1, 28);
  endtask

  task automatic drain(input string tag, input logic [127:0] exp, input int stall_idx);
    logic [31:0] ew;
    for (int i = 0; i < 4; i++) begin
      ew = exp[127-32*i -: 32];
      chk($sformatf("%s_m_valid%0d", tag, i), m_valid, 1);
      chk($sformatf("%s_m_data%0d", tag, i), m_data, ew);
      chk($sformatf("%s_m_last%0d", tag, i), m_last, (i == 3));
      if (i == stall_idx) begin
        m_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
          tick();
          chk($sformatf("%s_hold_data%0d", tag, j), m_data, ew);
          chk($sformatf("%s_hold_valid%0d", tag, j), m_valid, 1);
        end
        m_ready = 1'b1;
      end
      tick();
    end
    chk({tag, "_m_valid_after"}, m_valid, 0);
    chk({tag, "_s_ready_after"}, s_ready, 1);
  endtask

  initial begin
    // Reset values
    tick(); tick(); tick();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_aes_state", aes_state, 0);
    chk("rst_aes_key", aes_key, 0);
    rst = 1'b0;
    tick();

    // 4-word block with no key loaded
    wq = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    illegal("len4_nokey");

    // 7-word block
    wq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
    illegal("len7");

    // 12-word block
    wq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'ha, 32'hb, 32'hc};
    illegal("len12");

    // Full block, FIPS-197 C.2
    wq = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 32'h10111213, 32'h14151617,
           32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    send_q();
    chk("full_aes_start", aes_start, 1);
    chk("full_aes_key", aes_key, K);
    chk("full_aes_state", aes_state, P);
    chk("full_s_ready", s_ready, 0);
    chk("full_busy", busy, 1);
    tick();
    chk("full_gap_start", aes_start, 0);
    wait_mv("full");
    drain("full", C, 4);

    // Key reuse with same plaintext
    wq = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    send_q();
    chk("reuse_aes_key", aes_key, K);
    wait_mv("reuse");
    drain("reuse", C, 4);

    // Backpressure on a different plaintext
    wq = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
    send_q();
    chk("bp_aes_state", aes_state, P2);
    wait_mv("bp");
    drain("bp", P2 ^ K[191:64], 1);

    // Timeout with a dead core
    core_dead = 1'b1;
    wq = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    send_q();
    begin
      int unsigned n;
      logic seen_mv;
      n = 0;
      seen_mv = 1'b0;
      while (!err_timeout && n < 200) begin
        tick();
        seen_mv = seen_mv | m_valid;
        n++;
      end
      chk("to_cycle", cyc - t_acc, 66);
      chk("to_no_m_valid", seen_mv, 0);
    end
    chk("to_s_ready", s_ready, 1);
    chk("to_busy", busy, 0);
    tick();
    chk("to_pulse", err_timeout, 0);
    core_dead = 1'b0;

    // Reset mid-WAIT, then key must be gone
    wq = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    send_q();
    repeat (10) tick();
    chk("rw_busy_before", busy, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_s_ready", s_ready, 1);
    chk("rw_aes_key", aes_key, 0);
    quiet("rw_no_output", 40);
    wq = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    illegal("rw_len4");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
